// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the z80 bus slave and its trace FIFO.
//   wait_state_e : wait-state FSM encoding (IDLE, WAIT, HOLD)
//   trc_entry_t  : one committed write {io, addr, data}
//   IACK_DATA    : byte returned on di during interrupt acknowledge
package z80_bus_pkg;

    localparam int unsigned WAIT_CW   = 4;
    localparam logic [7:0]  IACK_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } wait_state_e;

    typedef struct packed {
        logic        io;
        logic [15:0] addr;
        logic [7:0]  data;
    } trc_entry_t;

    // IO writes are logged with only the low address byte.
    function automatic logic [15:0] trc_addr_of(input logic io, input logic [15:0] a);
        return io ? {8'h00, a[7:0]} : a;
    endfunction

endpackage

// File: rtl/z80_trace_fifo.sv
// Trace FIFO of committed bus writes.
//   clk, reset       : clock, synchronous active-high reset (empties FIFO, clears ovf)
//   push, push_data  : log one entry; dropped when full unless a pop happens on the same edge
//   pop              : drop head entry; ignored while empty
//   head, valid      : head entry and non-empty flag
//   count, ovf       : occupancy and sticky overflow flag
module z80_trace_fifo
    import z80_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  trc_entry_t               push_data,
    input  logic                     pop,
    output trc_entry_t               head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trc_entry_t      store [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_next;
    logic            full;
    logic            pop_ok;
    logic            push_ok;

    assign full       = (count == CW'(DEPTH));
    assign pop_ok     = pop && valid;
    // A pop on the same edge frees the slot the push needs.
    assign push_ok    = push && (!full || pop_ok);
    assign count_next = count + CW'(push_ok) - CW'(pop_ok);

    // Pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            count <= count_next;
            valid <= (count_next != '0);
            if (push && full && !pop_ok) ovf <= 1'b1;
        end
    end

    // Entry storage; when full with a pop, wr_ptr equals the departing head slot.
    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= push_data;
    end

    assign head = store[rd_ptr];

endmodule

// File: rtl/z80_bus_slave.sv
// Memory/IO bus slave for the tv80s core with programmable wait states
// and a trace FIFO of every committed write.
//   clk, reset                : clock, synchronous active-high reset
//   A, cpu_do                 : core address and write data
//   m1_n .. rfsh_n            : core strobes, active low
//   di, wait_n                : read data and wait request to the core
//   bd_we, bd_addr, bd_data   : backdoor memory write (loses to a bus memory write)
//   trc_*                     : trace FIFO head, pop, occupancy and overflow
module z80_bus_slave
    import z80_bus_pkg::*;
#(
    parameter int unsigned MEM_AW    = 16,
    parameter int unsigned MEM_WAIT  = 0,
    parameter int unsigned IO_WAIT   = 1,
    parameter int unsigned TRC_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  A,
    input  logic [7:0]                   cpu_do,
    input  logic                         m1_n,
    input  logic                         mreq_n,
    input  logic                         iorq_n,
    input  logic                         rd_n,
    input  logic                         wr_n,
    input  logic                         rfsh_n,
    output logic [7:0]                   di,
    output logic                         wait_n,
    input  logic                         bd_we,
    input  logic [15:0]                  bd_addr,
    input  logic [7:0]                   bd_data,
    input  logic                         trc_pop,
    output logic                         trc_valid,
    output logic                         trc_io,
    output logic [15:0]                  trc_addr,
    output logic [7:0]                   trc_data,
    output logic [$clog2(TRC_DEPTH):0]   trc_count,
    output logic                         trc_ovf
);

    localparam int unsigned         MEM_SIZE   = 1 << MEM_AW;
    localparam logic [WAIT_CW-1:0]  MEM_WAIT_C = WAIT_CW'(MEM_WAIT);
    localparam logic [WAIT_CW-1:0]  IO_WAIT_C  = WAIT_CW'(IO_WAIT);

    logic [7:0]          mem    [MEM_SIZE];
    logic [7:0]          io_mem [256];
    logic [7:0]          mem_q;
    logic [7:0]          io_q;

    wait_state_e         state;
    wait_state_e         state_next;
    logic [WAIT_CW-1:0]  wait_cnt;
    logic [WAIT_CW-1:0]  wait_cnt_next;
    logic [WAIT_CW-1:0]  wait_load;
    logic                wr_done;
    logic                wr_done_next;

    logic                iack;
    logic                bus_idle;
    logic                access_start;
    logic                commit;
    logic                commit_mem;
    logic                commit_io;
    trc_entry_t          trc_in;
    trc_entry_t          trc_head;

    assign iack         = !m1_n && !iorq_n;
    assign bus_idle     = mreq_n && iorq_n;
    assign access_start = !bus_idle && (!rd_n || !wr_n) && rfsh_n && !iack;
    assign wait_load    = !iorq_n ? IO_WAIT_C : MEM_WAIT_C;
    assign commit_mem   = commit && !mreq_n;
    assign commit_io    = commit && mreq_n && !iorq_n;

    // Registered read path: one-cycle latency from A to di.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= 8'hFF;
            io_q  <= 8'hFF;
        end else begin
            mem_q <= mem[A[MEM_AW-1:0]];
            io_q  <= io_mem[A[7:0]];
        end
    end

    always_comb begin
        di = mem_q;
        if (iack)         di = IACK_DATA;
        else if (!iorq_n) di = io_q;
    end

    // Array writes; a bus memory commit suppresses a coincident backdoor write.
    always_ff @(posedge clk) begin
        if (commit_mem)  mem[A[MEM_AW-1:0]] <= cpu_do;
        else if (bd_we)  mem[bd_addr[MEM_AW-1:0]] <= bd_data;
        if (commit_io)   io_mem[A[7:0]] <= cpu_do;
    end

    // Wait FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            wr_done  <= 1'b0;
            wait_n   <= 1'b1;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            wr_done  <= wr_done_next;
            wait_n   <= (state_next != ST_WAIT);
        end
    end

    // Wait FSM next state and write commit.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        wr_done_next  = wr_done;
        commit        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access_start) begin
                    if (wait_load != '0) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = wait_load;
                    end else begin
                        state_next    = ST_HOLD;
                    end
                end
            end
            ST_WAIT: begin
                // The counter hits zero on this edge: leave WAIT now.
                if (wait_cnt <= WAIT_CW'(1)) begin
                    state_next    = ST_HOLD;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt - WAIT_CW'(1);
                end
            end
            ST_HOLD: begin
                if (bus_idle) begin
                    state_next   = ST_IDLE;
                    wr_done_next = 1'b0;
                end else if (!wr_n && !wr_done && !reset) begin
                    commit       = 1'b1;
                    wr_done_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign trc_in.io   = commit_io;
    assign trc_in.addr = trc_addr_of(commit_io, A);
    assign trc_in.data = cpu_do;

    z80_trace_fifo #(
        .DEPTH (TRC_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (commit),
        .push_data (trc_in),
        .pop       (trc_pop),
        .head      (trc_head),
        .valid     (trc_valid),
        .count     (trc_count),
        .ovf       (trc_ovf)
    );

    assign trc_io   = trc_head.io;
    assign trc_addr = trc_head.addr;
    assign trc_data = trc_head.data;

endmodule

// File: tb/tb_z80_bus_slave.sv
// Self-checking bench: drives Z80-style bus cycles and compares against a
// behavioural model (byte arrays for memory/IO, a queue for the trace log).
module tb_z80_bus_slave;

    localparam int unsigned MW    = 2;
    localparam int unsigned IW    = 1;
    localparam int unsigned DEPTH = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [15:0]               A;
    logic [7:0]                cpu_do;
    logic                      m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [7:0]                di;
    logic                      wait_n;
    logic                      bd_we;
    logic [15:0]               bd_addr;
    logic [7:0]                bd_data;
    logic                      trc_pop;
    logic                      trc_valid, trc_io, trc_ovf;
    logic [15:0]               trc_addr;
    logic [7:0]                trc_data;
    logic [$clog2(DEPTH):0]    trc_count;

    z80_bus_slave #(
        .MEM_AW    (16),
        .MEM_WAIT  (MW),
        .IO_WAIT   (IW),
        .TRC_DEPTH (DEPTH)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .cpu_do    (cpu_do),
        .m1_n      (m1_n),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .rfsh_n    (rfsh_n),
        .di        (di),
        .wait_n    (wait_n),
        .bd_we     (bd_we),
        .bd_addr   (bd_addr),
        .bd_data   (bd_data),
        .trc_pop   (trc_pop),
        .trc_valid (trc_valid),
        .trc_io    (trc_io),
        .trc_addr  (trc_addr),
        .trc_data  (trc_data),
        .trc_count (trc_count),
        .trc_ovf   (trc_ovf)
    );

    always #5 clk = ~clk;

    // Reference model.
    logic [7:0]  mem_m [0:65535];
    bit          mem_k [0:65535];
    logic [7:0]  io_m  [0:255];
    bit          io_k  [0:255];
    logic [24:0] trq   [$];
    bit          ovf_m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input bit io, input logic [15:0] a, input logic [7:0] d);
        logic [15:0] ea;
        ea = io ? {8'h00, a[7:0]} : a;
        if (trq.size() < DEPTH) trq.push_back({io, ea, d});
        else ovf_m = 1'b1;
    endtask

    task automatic status_check(input string tag);
        chk({tag, "_count"}, 32'(trc_count), 32'(trq.size()));
        chk({tag, "_valid"}, 32'(trc_valid), 32'(trq.size() != 0));
        chk({tag, "_ovf"},   32'(trc_ovf),   32'(ovf_m));
    endtask

    task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
        mem_m[a] = d; mem_k[a] = 1'b1;
    endtask

    // Counts low wait_n cycles after the access starts; leaves the bus in its final T-state.
    task automatic wait_phase(input bit io, input string tag);
        int waits;
        int guard;
        waits = 0; guard = 0;
        do begin
            tick();
            if (!wait_n) waits++;
            guard++;
        end while (!wait_n && guard < 40);
        chk(tag, 32'(waits), io ? 32'(IW) : 32'(MW));
    endtask

    task automatic bus_write(input bit io, input logic [15:0] a, input logic [7:0] d,
                             input bit pop_c, input bit bd_c);
        bit popped;
        A = a; cpu_do = d; wr_n = 1'b0;
        if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
        wait_phase(io, "wr_wait");
        popped = 1'b0;
        if (pop_c && trq.size() > 0) begin trc_pop = 1'b1; popped = 1'b1; end
        if (bd_c) begin bd_we = 1'b1; bd_addr = a ^ 16'h0001; bd_data = ~d; end
        tick();
        trc_pop = 1'b0; bd_we = 1'b0;
        if (popped) void'(trq.pop_front());
        if (io) begin io_m[a[7:0]] = d; io_k[a[7:0]] = 1'b1; end
        else    begin mem_m[a] = d;     mem_k[a] = 1'b1;     end
        model_push(io, a, d);
        wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        tick();
    endtask

    task automatic bus_read(input bit io, input logic [15:0] a);
        A = a; rd_n = 1'b0;
        if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
        wait_phase(io, "rd_wait");
        if (io) chk("rd_io_data",  32'(di), 32'(io_m[a[7:0]]));
        else    chk("rd_mem_data", 32'(di), 32'(mem_m[a]));
        rd_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        tick();
    endtask

    task automatic pop_check();
        logic [24:0] e;
        e = trq[0];
        chk("pop_valid", 32'(trc_valid), 32'd1);
        chk("pop_io",    32'(trc_io),    32'(e[24]));
        chk("pop_addr",  32'(trc_addr),  32'(e[23:8]));
        chk("pop_data",  32'(trc_data),  32'(e[7:0]));
        trc_pop = 1'b1;
        tick();
        trc_pop = 1'b0;
        void'(trq.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        trq.delete();
        ovf_m = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ra;
        logic [7:0]  rd;
        logic [7:0]  ia;
        int          op;

        reset = 1'b1; A = '0; cpu_do = '0;
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0; trc_pop = 1'b0;
        ovf_m = 1'b0;
        repeat (3) tick();
        chk("rst_wait_n", 32'(wait_n),    32'd1);
        chk("rst_valid",  32'(trc_valid), 32'd0);
        chk("rst_count",  32'(trc_count), 32'd0);
        chk("rst_ovf",    32'(trc_ovf),   32'd0);
        chk("rst_di",     32'(di),        32'hFF);
        reset = 1'b0;
        tick();

        // RES 4,(IY+d) program: fetch the opcodes, read the operand, store it back.
        bd_write(16'h0000, 8'hFD); bd_write(16'h0001, 8'hCB);
        bd_write(16'h0002, 8'hA0); bd_write(16'h0003, 8'hA5);
        bd_write(16'hF141, 8'h44);
        m1_n = 1'b0;
        for (int i = 0; i < 4; i++) bus_read(1'b0, 16'(i));
        m1_n = 1'b1;
        bus_read(1'b0, 16'hF141);
        bus_write(1'b0, 16'hF141, 8'h44 & ~8'h10, 1'b0, 1'b0);
        status_check("res4");
        pop_check();

        // LD (HL),A
        bus_write(1'b0, 16'h8000, 8'h5A, 1'b0, 1'b0);
        status_check("ldhl");
        pop_check();
        bus_read(1'b0, 16'h8000);

        // OUT (7F),A with A on the upper address byte, then IN A,(7F).
        bus_write(1'b1, 16'hC37F, 8'hC3, 1'b0, 1'b0);
        pop_check();
        bus_read(1'b1, 16'h127F);

        // Interrupt acknowledge: forced FF, no wait, no trace.
        A = 16'h007F; m1_n = 1'b0; iorq_n = 1'b0;
        repeat (3) tick();
        chk("iack_di",     32'(di),     32'hFF);
        chk("iack_wait_n", 32'(wait_n), 32'd1);
        m1_n = 1'b1; iorq_n = 1'b1;
        tick();
        status_check("iack");

        // Refresh with write strobe low: ignored.
        bd_write(16'h4000, 8'h11);
        A = 16'h4000; cpu_do = 8'hEE; mreq_n = 1'b0; rfsh_n = 1'b0; wr_n = 1'b0;
        repeat (3) tick();
        chk("rfsh_wait_n", 32'(wait_n), 32'd1);
        mreq_n = 1'b1; rfsh_n = 1'b1; wr_n = 1'b1;
        tick();
        status_check("rfsh");
        bus_read(1'b0, 16'h4000);

        // Pop while empty is ignored.
        trc_pop = 1'b1; tick(); trc_pop = 1'b0;
        status_check("pop_empty");

        // Nine writes into an eight-deep log: last dropped, overflow set.
        for (int i = 0; i < 9; i++) bus_write(1'b0, 16'h9000 + 16'(i), 8'h30 + 8'(i), 1'b0, 1'b0);
        status_check("ovf");
        for (int i = 0; i < 8; i++) pop_check();
        status_check("drained");

        // Full FIFO: pop and push on the same edge.
        for (int i = 0; i < 8; i++) bus_write(1'b0, 16'hA100 + 16'(i), 8'h60 + 8'(i), 1'b0, 1'b0);
        bus_write(1'b0, 16'hA1F0, 8'hBE, 1'b1, 1'b0);
        status_check("full_pp");
        for (int i = 0; i < 8; i++) pop_check();

        // Backdoor colliding with a bus memory write is dropped.
        for (int i = 0; i < 32; i++) bd_write(16'hA000 + 16'(i), 8'($urandom));
        bus_write(1'b0, 16'hA004, 8'h77, 1'b0, 1'b1);
        bus_read(1'b0, 16'hA005);
        bus_read(1'b0, 16'hA004);

        // Randomised traffic against the model.
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 4));
            ra = 16'hA000 + 16'($urandom_range(0, 31));
            rd = 8'($urandom);
            ia = 8'($urandom_range(0, 15));
            case (op)
                0: bus_write(1'b0, ra, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1: bus_write(1'b1, {8'($urandom), ia}, rd, 1'b0, 1'b0);
                2: bus_read(1'b0, ra);
                3: if (io_k[ia]) bus_read(1'b1, {8'($urandom), ia});
                   else          bus_write(1'b1, {8'h00, ia}, rd, 1'b0, 1'b0);
                default: if (trq.size() > 0) pop_check();
                         else begin trc_pop = 1'b1; tick(); trc_pop = 1'b0; end
            endcase
            status_check("rnd");
        end

        // Reset during the second wait cycle of a memory write.
        do_reset();
        bus_write(1'b0, 16'hB100, 8'h42, 1'b0, 1'b0);
        bd_write(16'hB000, 8'h21);
        A = 16'hB000; cpu_do = 8'h99; mreq_n = 1'b0; wr_n = 1'b0;
        tick(); chk("rw_wait1", 32'(wait_n), 32'd0);
        tick(); chk("rw_wait2", 32'(wait_n), 32'd0);
        reset = 1'b1;
        tick();
        chk("rw_wait_n", 32'(wait_n),    32'd1);
        chk("rw_count",  32'(trc_count), 32'd0);
        mreq_n = 1'b1; wr_n = 1'b1; reset = 1'b0;
        trq.delete(); ovf_m = 1'b0;
        tick();
        status_check("rw");
        bus_read(1'b0, 16'hB000);

        // Reset on the edge that would commit the write.
        A = 16'hB000; cpu_do = 8'h88; mreq_n = 1'b0; wr_n = 1'b0;
        wait_phase(1'b0, "rh_wait");
        reset = 1'b1;
        tick();
        mreq_n = 1'b1; wr_n = 1'b1; reset = 1'b0;
        tick();
        status_check("rh");
        bus_read(1'b0, 16'hB000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/z80_bus_slave.md
Name: z80_bus_slave

Overview:
- Synthesizable memory/IO bus slave that sits directly downstream of the tv80s core.
- Consumes the core's bus strobes and address/data, stores memory and IO writes, and returns read data on di.
- Inserts programmable wait states.
- Logs every committed write into a trace FIFO, so benches check stores by popping entries instead of probing arrays.

Parameters:
- MEM_AW, 16, memory address width; the array holds 2**MEM_AW bytes and A is truncated to MEM_AW bits.
- MEM_WAIT, 0, wait cycles inserted per memory read/write cycle (0..15).
- IO_WAIT, 1, wait cycles inserted per IO read/write cycle (0..15).
- TRC_DEPTH, 8, trace FIFO entries (power of two, >=2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- A  in  16  core address bus.
- cpu_do  in  8  core data out.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  core strobes, active low.
- di  out  8  read data to core.
- wait_n  out  1  wait request to core, active low.
- bd_we  in  1  backdoor memory write (bench preload).
- bd_addr  in  16  backdoor address.
- bd_data  in  8  backdoor data.
- trc_pop  in  1  pop head entry.
- trc_valid  out  1  FIFO non-empty.
- trc_io  out  1  head entry is an IO write.
- trc_addr  out  16  head entry address (IO: {8'h00, A[7:0]}).
- trc_data  out  8  head entry data.
- trc_count  out  $clog2(TRC_DEPTH)+1  occupancy.
- trc_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset values: wait_n=1, trc_valid=0, trc_count=0, trc_ovf=0, wait FSM IDLE, write-done flag=0. Memory and IO array contents are not cleared. di follows the read registers, which reset to 8'hFF.
- Read path: each clk, mem_q <= mem[A] and io_q <= io[A[7:0]]. di = io_q when iorq_n=0, else mem_q. This gives one-cycle read latency.
- Interrupt acknowledge (m1_n=0 and iorq_n=0): di=8'hFF, no wait states, no write, no trace entry.
- Refresh (rfsh_n=0): ignored; no wait states, no write.
- Access start = first clk with (mreq_n=0 or iorq_n=0) and (rd_n=0 or wr_n=0) and not a refresh or interrupt acknowledge.
- Wait FSM states: IDLE, WAIT, HOLD.
  - IDLE -> WAIT on access start when the applicable count (MEM_WAIT or IO_WAIT) is nonzero. The counter loads that count, and wait_n=0 from the next cycle for exactly that many cycles.
  - IDLE -> HOLD on access start when the count is 0.
  - WAIT -> HOLD when the counter reaches 0; wait_n returns to 1.
  - HOLD -> IDLE when mreq_n and iorq_n are both 1.
- Writes: a write commits on the first clk in WAIT-expired or HOLD state with wr_n=0.
  - Memory if mreq_n=0, IO if iorq_n=0.
  - A write-done flag blocks further commits until the strobes deassert, so exactly one commit and one trace push occur per bus cycle.
- Backdoor: bd_we writes mem[bd_addr] on the same edge. If it coincides with a bus memory write commit, the bus write wins and the backdoor write is dropped.
- Trace FIFO:
  - Push on each write commit.
  - Pop when trc_pop and trc_valid; a pop while empty is ignored.
  - Push while full (and no simultaneous pop): entry dropped, trc_ovf set (cleared only by reset), existing contents preserved.
  - Push and pop in the same cycle while full: both take effect, count unchanged, trc_ovf unchanged.
  - Read and write pointers wrap modulo TRC_DEPTH.
- Reset mid-operation: the FSM returns to IDLE and wait_n=1 on the following edge, the FIFO empties, and in-flight writes are not committed.

Decomposition:
- Shared package z80_bus_pkg:
  - wait FSM state enum;
  - trace entry struct {io, addr[15:0], data[7:0]};
  - constant IACK_DATA=8'hFF.
- One sub-module: z80_trace_fifo (parameterized by TRC_DEPTH, carries the struct, provides count and overflow).
- The memory, IO arrays and wait FSM stay in the top module.

Test Plan:
- Preload via backdoor: 0000..0003 = FD CB A0 A5 (RES 4,(IY+d) with undocumented copy to L), F141=44, IY=F1A1, L=DC, MEM_WAIT=0 -> after 23 clocks PC=0004, L=44. FIFO holds one entry {io=0, F141, 44}; trc_count=1.
- MEM_WAIT=2, single LD (HL),A with HL=8000, A=5A -> wait_n low exactly 2 cycles in that M-cycle, one trace entry {0, 8000, 5A}, mem[8000]=5A.
- OUT (7F),A with A=C3 and IO_WAIT=1 -> one wait cycle, io[7F]=C3, trace {1, 007F, C3}; subsequent IN A,(7F) returns C3.
- Nine memory writes to 9000..9008 with TRC_DEPTH=8 and no pops -> trc_count=8, trc_ovf=1. Head entry is addr 9000; the ninth entry is absent on pop-out.
- When the FIFO is full, pop and write in the same cycle -> count stays 8, trc_ovf unchanged, and the new entry appears after 7 further pops.
- Reset asserted while wait_n=0 (MEM_WAIT=5, second wait cycle) -> wait_n=1 after the next edge, trc_count=0, and the pending write is absent from both memory and FIFO.
